instr_cache: RTL and testbench
==============================

Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache. It sits between the single-cycle CPU fetch port (PC in, INSTRUCTION out) and the instruction memory.
- A hit returns the instruction in the same cycle. A miss raises BUSYWAIT to stall the CPU while a 4-word block is fetched from the instruction memory over a busy-wait handshake.
- It is the responder side of the CPU's PC/INSTRUCTION fetch interface.

Parameters:
- NUM_BLOCKS, 8, number of cache lines. Must be a power of 2. Index width = log2(NUM_BLOCKS).
- ADDR_WIDTH, 10, PC bits decoded. Higher PC bits are ignored.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset. Asynchronous, active-high.
- READ  input  1  CPU fetch request valid.
- ADDRESS  input  32  byte PC from the CPU. Bits [1:0] ignored. Word offset = [3:2]. Index = [3+log2(NUM_BLOCKS):4]. Tag = remaining bits up to ADDR_WIDTH-1.
- INSTRUCTION  output  32  fetched instruction word.
- BUSYWAIT  output  1  stall request to the CPU; the PC must hold while this is high.
- MEM_READ  output  1  block read request to the instruction memory.
- MEM_ADDRESS  output  ADDR_WIDTH-4  block address = ADDRESS[ADDR_WIDTH-1:4].
- MEM_READDATA  input  128  block data. Word k = bits [32k+31:32k], little-endian word order.
- MEM_BUSYWAIT  input  1  memory busy; data is valid when this is low while MEM_READ is high.

Behaviour:
- Storage per line: valid bit, tag, 128-bit data.
- Reset (asynchronous): all valid bits = 0; state = IDLE; BUSYWAIT = 0; MEM_READ = 0; MEM_ADDRESS = 0; INSTRUCTION = 32'h0. Tag and data arrays are not cleared.
- HIT is combinational: READ & valid[index] & (tag[index] == ADDRESS tag).
- FSM has three states: IDLE, MEM_READ, UPDATE.

IDLE:
- INSTRUCTION = data[index] word[offset] when HIT.
- BUSYWAIT = READ & !HIT, asserted combinationally in the same cycle.
- MEM_READ = 0.
- Next state = MEM_READ if READ & !HIT; otherwise stay in IDLE.

MEM_READ:
- MEM_READ = 1, MEM_ADDRESS = block address of ADDRESS, BUSYWAIT = 1.
- Stay while MEM_BUSYWAIT = 1.
- At the first posedge with MEM_BUSYWAIT = 0: write MEM_READDATA to data[index], write tag[index], set valid[index] = 1, then go to UPDATE.

UPDATE:
- One cycle. MEM_READ = 0, BUSYWAIT = 1.
- Next state = IDLE. The access is now a hit, so BUSYWAIT drops in IDLE.

Latency:
- Hit: 0 cycles (same-cycle combinational read).
- Miss: 1 (IDLE→MEM_READ) + N memory busy cycles + 1 fill edge + 1 UPDATE, i.e. BUSYWAIT is high for N+3 cycles when the memory holds MEM_BUSYWAIT for N cycles.

Replacement and ordering:
- Direct-mapped: a miss overwrites the line unconditionally, with no write-back (read-only cache).
- ADDRESS and READ must be stable while BUSYWAIT = 1. The cache does not re-check HIT until it returns to IDLE.

Boundary conditions:
- READ = 0 in IDLE: BUSYWAIT = 0, INSTRUCTION holds its last value, no memory traffic.
- RESET during MEM_READ or UPDATE: immediately return to IDLE; MEM_READ and BUSYWAIT go low asynchronously; the partially filled line stays invalid.
- MEM_BUSYWAIT already low in the first MEM_READ cycle: the fill happens at that edge (N = 0, BUSYWAIT high for 3 cycles).
- Index wrap: PCs 0x000 and 0x080 (NUM_BLOCKS=8) map to line 0 with tags 0 and 1, and evict each other.
- Upper ADDRESS bits (>= ADDR_WIDTH) are ignored, so aliases hit the same line.
- Tag match with valid = 0 is a miss.

Test Plan:
- Reset, then READ=1, ADDRESS=0x000; memory holds MEM_BUSYWAIT for 3 cycles then supplies 128'h33333333_22222222_11111111_00000000 → BUSYWAIT high the same cycle; MEM_READ=1 with MEM_ADDRESS=0; BUSYWAIT high 6 cycles total; then INSTRUCTION=32'h00000000 and BUSYWAIT=0.
- After the fill, ADDRESS=0x004, 0x008, 0x00C → INSTRUCTION = 32'h11111111, 32'h22222222, 32'h33333333 in the same cycle, BUSYWAIT=0, no MEM_READ.
- ADDRESS=0x080 → miss with MEM_ADDRESS=8, line 0 refilled with tag 1. Returning to ADDRESS=0x000 → miss again with MEM_ADDRESS=0.
- RESET pulsed during the 2nd MEM_READ cycle → MEM_READ=0 and BUSYWAIT=0 within the same timestep. Re-fetching 0x000 then misses (valid cleared).
- Memory responds with MEM_BUSYWAIT=0 immediately → BUSYWAIT high exactly 3 cycles and data is correct.
- READ=0 with any ADDRESS for 10 cycles → BUSYWAIT=0, MEM_READ=0 throughout.

Source files
------------

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave  : the cache's view (answers the CPU, requests from memory).
// master : the environment's view (CPU fetch port + instruction memory).
interface instr_cache_if #(
  parameter int ADDR_WIDTH = 10
);
  // CPU fetch port
  logic                  READ;
  logic [31:0]           ADDRESS;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  // instruction memory port
  logic                  MEM_READ;
  logic [ADDR_WIDTH-5:0] MEM_ADDRESS;
  logic [127:0]          MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache, 4 words per line.
// Hits answer in the same cycle; misses stall the CPU via BUSYWAIT while
// the whole line is fetched from instruction memory.
module instr_cache #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_WIDTH = 10
) (
  input logic          CLK,
  input logic          RESET,
  instr_cache_if.slave bus
);
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int TW = ADDR_WIDTH - 4 - IW;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_READ = 2'd1;
  localparam logic [1:0] ST_UPDATE   = 2'd2;

  logic [1:0] state, state_nxt;

  // line storage; only the valid bits are reset
  logic [NUM_BLOCKS-1:0]          valid;
  logic [NUM_BLOCKS-1:0][TW-1:0]  tags;
  logic [NUM_BLOCKS-1:0][127:0]   data;

  // address decode
  logic [1:0]            off;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag_in;
  logic [ADDR_WIDTH-5:0] blk_addr;
  logic                  unused_addr;

  assign off         = bus.ADDRESS[3:2];
  assign idx         = bus.ADDRESS[4+IW-1:4];
  assign tag_in      = bus.ADDRESS[ADDR_WIDTH-1:4+IW];
  assign blk_addr    = bus.ADDRESS[ADDR_WIDTH-1:4];
  assign unused_addr = ^{bus.ADDRESS[31:ADDR_WIDTH], bus.ADDRESS[1:0]};

  logic        hit;
  logic [31:0] hit_word;
  logic [31:0] instr_q;
  logic        fill;

  assign hit      = bus.READ & valid[idx] & (tags[idx] == tag_in);
  assign hit_word = data[idx][{off, 5'b0} +: 32];
  assign fill     = (state == ST_MEM_READ) & ~bus.MEM_BUSYWAIT;

  // INSTRUCTION follows the array on a hit and otherwise holds the last word
  assign bus.INSTRUCTION = hit ? hit_word : instr_q;

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // last delivered instruction, shown while no hit is being presented
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)    instr_q <= 32'h0;
    else if (hit) instr_q <= hit_word;
  end

  // valid bits: cleared by reset, set when a line fill completes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     valid      <= '0;
    else if (fill) valid[idx] <= 1'b1;
  end

  // tag/data fill; a miss overwrites the line unconditionally
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[idx] <= tag_in;
      data[idx] <= bus.MEM_READDATA;
    end
  end

  // next state and handshake outputs; RESET forces outputs low at once,
  // since with valid cleared an IDLE miss would otherwise raise BUSYWAIT
  always_comb begin
    state_nxt       = state;
    bus.BUSYWAIT    = 1'b0;
    bus.MEM_READ    = 1'b0;
    bus.MEM_ADDRESS = '0;
    case (state)
      ST_IDLE: begin
        bus.BUSYWAIT = bus.READ & ~hit;
        if (bus.READ & ~hit) state_nxt = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        bus.BUSYWAIT    = 1'b1;
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = blk_addr;
        if (!bus.MEM_BUSYWAIT) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        bus.BUSYWAIT = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (RESET) begin
      bus.BUSYWAIT    = 1'b0;
      bus.MEM_READ    = 1'b0;
      bus.MEM_ADDRESS = '0;
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: fills, hits, eviction, aliasing,
// reset mid-fill and idle behaviour, with a small busy-wait memory model.
module tb_instr_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   n_wait = 0;
  int   cnt = 0;

  localparam logic [127:0] D0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] D1 = 128'h77777777_66666666_55555555_44444444;

  always #5 clk = ~clk;

  instr_cache_if #(.ADDR_WIDTH(10)) bus();

  instr_cache #(.NUM_BLOCKS(8), .ADDR_WIDTH(10)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  // memory holds busy for n_wait cycles of each MEM_READ burst
  always @(posedge clk) cnt <= bus.MEM_READ ? cnt + 1 : 0;
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (cnt < n_wait);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present a missing address and follow the whole stall
  task automatic do_miss(input string tag, input logic [31:0] addr, input int nw,
                         input logic [127:0] blk, input logic [5:0] exp_ma,
                         input int exp_cycles, input logic [31:0] exp_instr);
    int cycles;
    logic saw_mr;
    logic [5:0] ma;
    @(negedge clk);
    n_wait = nw;
    bus.MEM_READDATA = blk;
    bus.ADDRESS = addr;
    bus.READ = 1'b1;
    #1;
    check({tag, "_busy_now"}, {31'b0, bus.BUSYWAIT}, 32'd1);
    cycles = 0;
    saw_mr = 1'b0;
    ma = '1;
    while (bus.BUSYWAIT === 1'b1 && cycles < 50) begin
      if (bus.MEM_READ === 1'b1 && !saw_mr) begin
        saw_mr = 1'b1;
        ma = bus.MEM_ADDRESS;
      end
      cycles++;
      @(negedge clk);
      #1;
    end
    check({tag, "_mem_read_seen"}, {31'b0, saw_mr}, 32'd1);
    check({tag, "_mem_addr"}, {26'b0, ma}, {26'b0, exp_ma});
    check({tag, "_busy_cycles"}, cycles, exp_cycles);
    check({tag, "_instr"}, bus.INSTRUCTION, exp_instr);
    check({tag, "_mem_read_off"}, {31'b0, bus.MEM_READ}, 32'd0);
  endtask

  // same-cycle hit on a present line
  task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_instr);
    @(negedge clk);
    bus.ADDRESS = addr;
    bus.READ = 1'b1;
    #1;
    check({tag, "_instr"}, bus.INSTRUCTION, exp_instr);
    check({tag, "_busy"}, {31'b0, bus.BUSYWAIT}, 32'd0);
    check({tag, "_mem_read"}, {31'b0, bus.MEM_READ}, 32'd0);
  endtask

  initial begin
    bus.READ = 1'b0;
    bus.ADDRESS = 32'h0;
    bus.MEM_READDATA = '0;
    #1;
    check("rst_busy", {31'b0, bus.BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
    check("rst_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'd0);
    check("rst_instr", bus.INSTRUCTION, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss on line 0, tag 0 (valid clear even though stale tag may match)
    do_miss("miss0", 32'h000, 3, D0, 6'd0, 6, 32'h00000000);
    do_hit("hit4", 32'h004, 32'h11111111);
    do_hit("hit8", 32'h008, 32'h22222222);
    do_hit("hitC", 32'h00C, 32'h33333333);
    // upper bits beyond ADDR_WIDTH ignored
    do_hit("alias", 32'hFFFF_FC04, 32'h11111111);

    // index wrap: 0x080 evicts 0x000 and back again
    do_miss("miss80", 32'h080, 2, D1, 6'd8, 5, 32'h44444444);
    do_hit("hit8C", 32'h08C, 32'h77777777);
    do_miss("remiss0", 32'h000, 1, D0, 6'd0, 4, 32'h00000000);

    // reset in the second MEM_READ cycle of a miss
    @(negedge clk);
    n_wait = 5;
    bus.MEM_READDATA = D1;
    bus.ADDRESS = 32'h080;
    bus.READ = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("mid_mem_read", {31'b0, bus.MEM_READ}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
    check("async_busy", {31'b0, bus.BUSYWAIT}, 32'd0);
    bus.READ = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_instr", bus.INSTRUCTION, 32'h0);

    // line 0 invalid again: miss with zero memory wait
    do_miss("miss_n0", 32'h008, 0, D0, 6'd0, 3, 32'h22222222);
    do_hit("hit0", 32'h000, 32'h00000000);
    do_hit("hit8b", 32'h008, 32'h22222222);

    // idle: no requests, no stall, instruction holds
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.READ = 1'b0;
      bus.ADDRESS = $urandom;
      #1;
      check($sformatf("idle%0d_busy", i), {31'b0, bus.BUSYWAIT}, 32'd0);
      check($sformatf("idle%0d_mem_read", i), {31'b0, bus.MEM_READ}, 32'd0);
      check($sformatf("idle%0d_instr", i), bus.INSTRUCTION, 32'h22222222);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
